// File: rtl/third_mode_sequencer.sv
// Third-mode sequencer: requests entry into third mode, runs a seconds
// countdown, then requests a return to standby (or exits early on menu).
`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef OFF_MODE
`define OFF_MODE 2'd0
`endif
`ifndef STAND_MODE
`define STAND_MODE 2'd1
`endif
`ifndef THIRD_MODE
`define THIRD_MODE 2'd2
`endif

module third_mode_sequencer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int RUN_SECONDS   = 60
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [`MODE_WIDTH-1:0] current_mode,
    input  logic                   enter_toggle,
    input  logic                   menu_signal,
    output logic                   mode_req,
    output logic [`MODE_WIDTH-1:0] mode_req_value,
    output logic                   running,
    output logic [7:0]             remaining_sec,
    output logic [1:0]             state_o
);

    localparam int CNT_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0] RUN_LOAD = 8'(RUN_SECONDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ_ENTER = 2'd1,
        RUN       = 2'd2,
        REQ_EXIT  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       sub_cnt_q;
    logic [7:0]             rem_q;
    logic                   mode_req_q;
    logic [`MODE_WIDTH-1:0] mode_req_value_q;
    logic                   running_q;
    logic                   enter_q;
    logic                   menu_q;

    logic enter_edge;
    logic menu_edge;
    logic wrap;
    logic is_off;
    logic is_stand;
    logic is_third;

    always_comb begin
        enter_edge = enter_toggle & ~enter_q;
        menu_edge  = menu_signal & ~menu_q;
        wrap       = (sub_cnt_q == CNT_LAST);
        is_off     = (current_mode == `OFF_MODE);
        is_stand   = (current_mode == `STAND_MODE);
        is_third   = (current_mode == `THIRD_MODE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            sub_cnt_q        <= '0;
            rem_q            <= 8'd0;
            mode_req_q       <= 1'b0;
            mode_req_value_q <= `STAND_MODE;
            running_q        <= 1'b0;
            enter_q          <= 1'b0;
            menu_q           <= 1'b0;
        end else begin
            enter_q <= enter_toggle;
            menu_q  <= menu_signal;
            // Power-off overrides every other transition from any state.
            if (is_off) begin
                state_q          <= IDLE;
                sub_cnt_q        <= '0;
                rem_q            <= 8'd0;
                mode_req_q       <= 1'b0;
                mode_req_value_q <= `STAND_MODE;
                running_q        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (enter_edge && is_stand) begin
                            state_q          <= REQ_ENTER;
                            mode_req_q       <= 1'b1;
                            mode_req_value_q <= `THIRD_MODE;
                        end
                    end
                    REQ_ENTER: begin
                        if (is_third) begin
                            state_q    <= RUN;
                            mode_req_q <= 1'b0;
                            running_q  <= 1'b1;
                            rem_q      <= RUN_LOAD;
                            sub_cnt_q  <= '0;
                        end
                    end
                    RUN: begin
                        if (!is_third) begin
                            // Someone else moved the mode: leave quietly.
                            state_q   <= IDLE;
                            running_q <= 1'b0;
                            rem_q     <= 8'd0;
                            sub_cnt_q <= '0;
                        end else if (menu_edge || (wrap && rem_q <= 8'd1)) begin
                            // Menu freezes the countdown; a final wrap lands on zero.
                            state_q          <= REQ_EXIT;
                            mode_req_q       <= 1'b1;
                            mode_req_value_q <= `STAND_MODE;
                            running_q        <= 1'b0;
                            sub_cnt_q        <= '0;
                            if (!menu_edge) begin
                                rem_q <= 8'd0;
                            end
                        end else if (wrap) begin
                            sub_cnt_q <= '0;
                            rem_q     <= rem_q - 8'd1;
                        end else begin
                            sub_cnt_q <= sub_cnt_q + CNT_W'(1);
                        end
                    end
                    REQ_EXIT: begin
                        if (!is_third) begin
                            state_q    <= IDLE;
                            mode_req_q <= 1'b0;
                            rem_q      <= 8'd0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mode_req       = mode_req_q;
    assign mode_req_value = mode_req_value_q;
    assign running        = running_q;
    assign remaining_sec  = rem_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_third_mode_sequencer.sv
// Scoreboard bench for third_mode_sequencer with TICKS_PER_SEC=4, RUN_SECONDS=3.
`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef OFF_MODE
`define OFF_MODE 2'd0
`endif
`ifndef STAND_MODE
`define STAND_MODE 2'd1
`endif
`ifndef THIRD_MODE
`define THIRD_MODE 2'd2
`endif

module tb_third_mode_sequencer;

    localparam int W = 14;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENTER = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_EXIT  = 2'd3;
    localparam logic [1:0] OFF     = `OFF_MODE;
    localparam logic [1:0] STAND   = `STAND_MODE;
    localparam logic [1:0] THIRD   = `THIRD_MODE;
    localparam logic [7:0] DC      = 8'hFF;

    logic       clk;
    logic       rstn;
    logic [1:0] current_mode;
    logic       enter_toggle;
    logic       menu_signal;
    logic       mode_req;
    logic [1:0] mode_req_value;
    logic       running;
    logic [7:0] remaining_sec;
    logic [1:0] state_o;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks;
    int           n_errors;

    third_mode_sequencer #(.TICKS_PER_SEC(4), .RUN_SECONDS(3)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .current_mode   (current_mode),
        .enter_toggle   (enter_toggle),
        .menu_signal    (menu_signal),
        .mode_req       (mode_req),
        .mode_req_value (mode_req_value),
        .running        (running),
        .remaining_sec  (remaining_sec),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Expected layout: {state[1:0], mode_req, value[1:0], running, rem[7:0]}.
    // Value is only compared while mode_req is expected high; rem=DC skips rem.
    task automatic compare_out();
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {state_o, mode_req, mode_req_value, running, remaining_sec};
        if (!e[11]) a[10:9] = e[10:9];
        if (e[7:0] == DC) a[7:0] = DC;
        check(t, a, e);
    endtask

    task automatic step(input string tag, input logic [1:0] st, input logic req,
                        input logic [1:0] val, input logic run, input logic [7:0] rem);
        exp_q.push_back({st, req, val, run, rem});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Runs one second of RUN: three held cycles then the decrement.
    task automatic run_second(input string tag, input logic [7:0] sec);
        for (int i = 0; i < 3; i++) step(tag, S_RUN, 1'b0, THIRD, 1'b1, sec);
        step(tag, S_RUN, 1'b0, THIRD, 1'b1, sec - 8'd1);
    endtask

    task automatic enter_and_ack(input string tag);
        enter_toggle = 1'b1;
        step({tag, "_req"}, S_ENTER, 1'b1, THIRD, 1'b0, 8'd0);
        enter_toggle = 1'b0;
        current_mode = THIRD;
        step({tag, "_run"}, S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rstn         = 1'b0;
        current_mode = STAND;
        enter_toggle = 1'b0;
        menu_signal  = 1'b0;
        step("reset", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        check("reset_value", {12'd0, mode_req_value}, {12'd0, STAND});
        rstn = 1'b1;

        // Full timed run with natural expiry.
        enter_toggle = 1'b1;
        step("enter_req", S_ENTER, 1'b1, THIRD, 1'b0, 8'd0);
        enter_toggle = 1'b0;
        step("enter_hold", S_ENTER, 1'b1, THIRD, 1'b0, 8'd0);
        current_mode = THIRD;
        step("run_start", S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
        run_second("sec3", 8'd3);
        run_second("sec2", 8'd2);
        for (int i = 0; i < 3; i++) step("sec1", S_RUN, 1'b0, THIRD, 1'b1, 8'd1);
        step("expire", S_EXIT, 1'b1, STAND, 1'b0, 8'd0);
        step("exit_hold", S_EXIT, 1'b1, STAND, 1'b0, 8'd0);
        current_mode = STAND;
        step("exit_ack", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);

        // Menu in IDLE ignored; enter during RUN discarded; menu exit freezes count.
        menu_signal = 1'b1;
        step("menu_idle", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        menu_signal = 1'b0;
        enter_and_ack("m");
        enter_toggle = 1'b1;
        step("enter_in_run", S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
        enter_toggle = 1'b0;
        step("m_sec3", S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
        step("m_sec3", S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
        step("m_dec", S_RUN, 1'b0, THIRD, 1'b1, 8'd2);
        menu_signal = 1'b1;
        step("menu_exit", S_EXIT, 1'b1, STAND, 1'b0, 8'd2);
        menu_signal = 1'b0;
        step("menu_freeze", S_EXIT, 1'b1, STAND, 1'b0, 8'd2);
        current_mode = STAND;
        step("menu_ack", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        step("no_queue", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);

        // Menu edge coincident with the final wrap.
        enter_and_ack("w");
        run_second("w3", 8'd3);
        run_second("w2", 8'd2);
        for (int i = 0; i < 3; i++) step("w1", S_RUN, 1'b0, THIRD, 1'b1, 8'd1);
        menu_signal = 1'b1;
        step("both_exit", S_EXIT, 1'b1, STAND, 1'b0, DC);
        menu_signal = 1'b0;
        step("both_hold1", S_EXIT, 1'b1, STAND, 1'b0, DC);
        step("both_hold2", S_EXIT, 1'b1, STAND, 1'b0, DC);
        current_mode = STAND;
        step("both_ack", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);

        // OFF during REQ_ENTER and during RUN; enter while OFF ignored.
        enter_toggle = 1'b1;
        step("o_req", S_ENTER, 1'b1, THIRD, 1'b0, 8'd0);
        enter_toggle = 1'b0;
        current_mode = OFF;
        step("off_enter", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        enter_toggle = 1'b1;
        step("enter_off", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        enter_toggle = 1'b0;
        current_mode = STAND;
        step("back_stand", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        enter_and_ack("o");
        step("o_sub", S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
        current_mode = OFF;
        step("off_run", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        current_mode = STAND;

        // External override out of RUN: no request raised.
        enter_and_ack("x");
        current_mode = STAND;
        step("override", S_IDLE, 1'b0, STAND, 1'b0, DC);
        step("override_q", S_IDLE, 1'b0, STAND, 1'b0, DC);

        // Asynchronous reset mid-run, then entry with enter already high.
        enter_and_ack("r");
        step("r_sub", S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
        rstn = 1'b0;
        #1;
        check("async_rst", {state_o, mode_req, mode_req_value, running, remaining_sec},
              {S_IDLE, 1'b0, STAND, 1'b0, 8'd0});
        current_mode = STAND;
        enter_toggle = 1'b1;
        step("in_reset", S_IDLE, 1'b0, STAND, 1'b0, 8'd0);
        rstn = 1'b1;
        step("post_rst_edge", S_ENTER, 1'b1, THIRD, 1'b0, 8'd0);
        enter_toggle = 1'b0;
        current_mode = THIRD;
        step("post_rst_run", S_RUN, 1'b0, THIRD, 1'b1, 8'd3);
        run_second("post_rst_dec", 8'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
